// File: rtl/e6_gpio_axil_slave.sv
// GPIO block behind an AXI4-Lite slave: output data, direction, synchronized
// input readback and a rising-edge interrupt status with a level irq.
module e6_gpio_axil_slave #(
  parameter int GPIO_WIDTH         = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4
) (
  input  logic                          ACLK,
  input  logic                          ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_AWADDR,
  input  logic [2:0]                    S_AXI_AWPROT,
  input  logic                          S_AXI_AWVALID,
  output logic                          S_AXI_AWREADY,
  input  logic [31:0]                   S_AXI_WDATA,
  input  logic [3:0]                    S_AXI_WSTRB,
  input  logic                          S_AXI_WVALID,
  output logic                          S_AXI_WREADY,
  output logic [1:0]                    S_AXI_BRESP,
  output logic                          S_AXI_BVALID,
  input  logic                          S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0] S_AXI_ARADDR,
  input  logic [2:0]                    S_AXI_ARPROT,
  input  logic                          S_AXI_ARVALID,
  output logic                          S_AXI_ARREADY,
  output logic [31:0]                   S_AXI_RDATA,
  output logic [1:0]                    S_AXI_RRESP,
  output logic                          S_AXI_RVALID,
  input  logic                          S_AXI_RREADY,
  input  logic [GPIO_WIDTH-1:0]         gpio_in,
  output logic [GPIO_WIDTH-1:0]         gpio_out,
  output logic [GPIO_WIDTH-1:0]         gpio_oe,
  output logic                          irq
);

  localparam logic [1:0] REG_DATA_OUT = 2'd0;
  localparam logic [1:0] REG_DIR      = 2'd1;
  localparam logic [1:0] REG_DATA_IN  = 2'd2;
  localparam logic [1:0] REG_IRQ_STAT = 2'd3;

  logic                  aw_ready_r, w_ready_r, b_valid_r, ar_ready_r, r_valid_r, irq_r;
  logic [31:0]           r_data_r;
  logic [GPIO_WIDTH-1:0] data_out_r, dir_r, irq_stat_r, sync1_r, sync2_r, sync3_r;

  logic                  wr_fire_s, rd_fire_s;
  logic [31:0]           wmask_s, rd_mux_s;
  logic [GPIO_WIDTH-1:0] data_out_nx_s, dir_nx_s, irq_clr_s, irq_set_s, irq_stat_nx_s;
  logic                  unused_s;

  function automatic logic [31:0] strb_to_mask(input logic [3:0] strb);
    logic [31:0] m;
    m = 32'd0;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = {8{strb[i]}};
    return m;
  endfunction

  function automatic logic [31:0] zext(input logic [GPIO_WIDTH-1:0] v);
    logic [31:0] r;
    r = 32'd0;
    r[GPIO_WIDTH-1:0] = v;
    return r;
  endfunction

  function automatic logic [GPIO_WIDTH-1:0] merge(input logic [GPIO_WIDTH-1:0] old,
                                                  input logic [31:0] wdata,
                                                  input logic [31:0] mask);
    return (old & ~mask[GPIO_WIDTH-1:0]) | (wdata[GPIO_WIDTH-1:0] & mask[GPIO_WIDTH-1:0]);
  endfunction

  assign wr_fire_s = aw_ready_r & w_ready_r & S_AXI_AWVALID & S_AXI_WVALID;
  assign rd_fire_s = ar_ready_r & S_AXI_ARVALID;
  assign wmask_s   = strb_to_mask(S_AXI_WSTRB);
  assign unused_s  = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR, S_AXI_ARADDR};

  // Next-state of the writable registers; a rising input edge beats a W1C clear.
  always_comb begin
    data_out_nx_s = data_out_r;
    dir_nx_s      = dir_r;
    irq_clr_s     = {GPIO_WIDTH{1'b0}};
    if (wr_fire_s) begin
      case (S_AXI_AWADDR[3:2])
        REG_DATA_OUT: data_out_nx_s = merge(data_out_r, S_AXI_WDATA, wmask_s);
        REG_DIR:      dir_nx_s      = merge(dir_r, S_AXI_WDATA, wmask_s);
        REG_IRQ_STAT: irq_clr_s     = S_AXI_WDATA[GPIO_WIDTH-1:0] & wmask_s[GPIO_WIDTH-1:0];
        default:      irq_clr_s     = {GPIO_WIDTH{1'b0}};
      endcase
    end else begin
      irq_clr_s = {GPIO_WIDTH{1'b0}};
    end
    irq_set_s     = sync2_r & ~sync3_r & ~dir_r;
    irq_stat_nx_s = (irq_stat_r & ~irq_clr_s) | irq_set_s;
  end

  // Read data selection, zero-extended to the bus width.
  always_comb begin
    case (S_AXI_ARADDR[3:2])
      REG_DATA_OUT: rd_mux_s = zext(data_out_r);
      REG_DIR:      rd_mux_s = zext(dir_r);
      REG_DATA_IN:  rd_mux_s = zext(sync2_r);
      REG_IRQ_STAT: rd_mux_s = zext(irq_stat_r);
      default:      rd_mux_s = 32'd0;
    endcase
  end

  // AXI write and read channel handshakes.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_ready_r <= 1'b0;
      w_ready_r  <= 1'b0;
      b_valid_r  <= 1'b0;
      ar_ready_r <= 1'b0;
      r_valid_r  <= 1'b0;
      r_data_r   <= 32'd0;
    end else begin
      if (S_AXI_AWVALID && S_AXI_WVALID && !b_valid_r && !(aw_ready_r || w_ready_r)) begin
        aw_ready_r <= 1'b1;
        w_ready_r  <= 1'b1;
      end else begin
        aw_ready_r <= 1'b0;
        w_ready_r  <= 1'b0;
      end
      if (wr_fire_s)         b_valid_r <= 1'b1;
      else if (S_AXI_BREADY) b_valid_r <= 1'b0;
      ar_ready_r <= S_AXI_ARVALID && !r_valid_r && !ar_ready_r;
      if (rd_fire_s) begin
        r_valid_r <= 1'b1;
        r_data_r  <= rd_mux_s;
      end else if (S_AXI_RREADY) begin
        r_valid_r <= 1'b0;
      end
    end
  end

  // Register file, input synchronizer chain and registered interrupt.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      data_out_r <= {GPIO_WIDTH{1'b0}};
      dir_r      <= {GPIO_WIDTH{1'b0}};
      irq_stat_r <= {GPIO_WIDTH{1'b0}};
      sync1_r    <= {GPIO_WIDTH{1'b0}};
      sync2_r    <= {GPIO_WIDTH{1'b0}};
      sync3_r    <= {GPIO_WIDTH{1'b0}};
      irq_r      <= 1'b0;
    end else begin
      data_out_r <= data_out_nx_s;
      dir_r      <= dir_nx_s;
      irq_stat_r <= irq_stat_nx_s;
      sync1_r    <= gpio_in;
      sync2_r    <= sync1_r;
      sync3_r    <= sync2_r;
      irq_r      <= |irq_stat_r;
    end
  end

  assign S_AXI_AWREADY = aw_ready_r;
  assign S_AXI_WREADY  = w_ready_r;
  assign S_AXI_BRESP   = 2'b00;
  assign S_AXI_BVALID  = b_valid_r;
  assign S_AXI_ARREADY = ar_ready_r;
  assign S_AXI_RDATA   = r_data_r;
  assign S_AXI_RRESP   = 2'b00;
  assign S_AXI_RVALID  = r_valid_r;
  assign gpio_out      = data_out_r;
  assign gpio_oe       = dir_r;
  assign irq           = irq_r;

endmodule

// File: tb/tb_e6_gpio_axil_slave.sv
// Self-checking bench for e6_gpio_axil_slave; read results are checked
// against a queue of expected values filled when each read is issued.
module tb_e6_gpio_axil_slave;
  localparam int GW = 32;

  logic          aclk = 1'b0;
  logic          areset;
  logic [3:0]    awaddr, araddr;
  logic [2:0]    awprot, arprot;
  logic          awvalid, awready, wvalid, wready, bvalid, bready;
  logic [31:0]   wdata, rdata;
  logic [3:0]    wstrb;
  logic [1:0]    bresp, rresp;
  logic          arvalid, arready, rvalid, rready;
  logic [GW-1:0] gpio_in, gpio_out, gpio_oe;
  logic          irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_q[$];

  always #5 aclk = ~aclk;

  e6_gpio_axil_slave #(.GPIO_WIDTH(GW), .C_S_AXI_ADDR_WIDTH(4)) dut (
    .ACLK(aclk), .ARESET(areset),
    .S_AXI_AWADDR(awaddr), .S_AXI_AWPROT(awprot), .S_AXI_AWVALID(awvalid), .S_AXI_AWREADY(awready),
    .S_AXI_WDATA(wdata), .S_AXI_WSTRB(wstrb), .S_AXI_WVALID(wvalid), .S_AXI_WREADY(wready),
    .S_AXI_BRESP(bresp), .S_AXI_BVALID(bvalid), .S_AXI_BREADY(bready),
    .S_AXI_ARADDR(araddr), .S_AXI_ARPROT(arprot), .S_AXI_ARVALID(arvalid), .S_AXI_ARREADY(arready),
    .S_AXI_RDATA(rdata), .S_AXI_RRESP(rresp), .S_AXI_RVALID(rvalid), .S_AXI_RREADY(rready),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  task automatic do_reset();
    areset = 1'b1;
    awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0; arvalid = 1'b0; rready = 1'b0;
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
  endtask

  task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
    int n;
    @(negedge aclk);
    awaddr = a; wdata = d; wstrb = s; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    checks++;
    if (bvalid !== 1'b1 || bresp !== 2'b00) begin
      errors++;
      $display("FAIL write_resp addr=%h bvalid=%b bresp=%b, required bvalid=1 bresp=00", a, bvalid, bresp);
    end
    @(negedge aclk);
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a, input logic [31:0] expv);
    int n;
    logic [31:0] e;
    exp_q.push_back(expv);
    @(negedge aclk);
    araddr = a; arvalid = 1'b1; rready = 1'b1;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 20) begin @(negedge aclk); n++; end
    e = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== e || rresp !== 2'b00) begin
      errors++;
      $display("FAIL read addr=%h rvalid=%b rdata=%h rresp=%b, required rdata=%h rresp=00", a, rvalid, rdata, rresp, e);
    end
    @(negedge aclk);
    rready = 1'b0;
  endtask

  task automatic test_reset();
    gpio_in = {GW{1'b0}};
    do_reset();
    checks++;
    if ({awready, wready, arready, bvalid, rvalid, irq} !== 6'b0 || gpio_out !== 32'd0 ||
        gpio_oe !== 32'd0 || rdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_state rdy/valid/irq=%b gpio_out=%h gpio_oe=%h rdata=%h, required all 0",
               {awready, wready, arready, bvalid, rvalid, irq}, gpio_out, gpio_oe, rdata);
    end
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'd0);
  endtask

  task automatic test_basic_rw();
    axi_write(4'h0, 32'h1, 4'hF);
    axi_write(4'h4, 32'h2, 4'hF);
    axi_read(4'h0, 32'h1);
    axi_read(4'h4, 32'h2);
    checks++;
    if (gpio_out !== 32'h1 || gpio_oe !== 32'h2) begin
      errors++;
      $display("FAIL pins gpio_out=%h gpio_oe=%h, required 00000001 00000002", gpio_out, gpio_oe);
    end
  endtask

  task automatic test_strobe();
    gpio_in = {GW{1'b0}};
    do_reset();
    axi_write(4'h0, 32'hFFFF_FFFF, 4'b0010);
    axi_read(4'h0, 32'h0000_FF00);
    axi_write(4'h4, 32'h1234_5678, 4'b1001);
    axi_read(4'h4, 32'h1200_0078);
    axi_write(4'h8, 32'hFFFF_FFFF, 4'hF);
    axi_read(4'h8, 32'h0);
    checks++;
    if (gpio_out !== 32'h0000_FF00) begin
      errors++;
      $display("FAIL strobe_pins gpio_out=%h, required 0000ff00", gpio_out);
    end
  endtask

  task automatic test_irq();
    gpio_in = {GW{1'b0}};
    do_reset();
    @(negedge aclk);
    gpio_in = 32'h5;
    repeat (3) @(negedge aclk);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_early irq=%b, required 0", irq); end
    @(negedge aclk);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_rise irq=%b, required 1", irq); end
    axi_read(4'h8, 32'h5);
    axi_read(4'hC, 32'h5);
    axi_write(4'hC, 32'h1, 4'hF);
    axi_read(4'hC, 32'h4);
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL irq_hold irq=%b, required 1", irq); end
    // falling edge on bit 0 must not set anything
    @(negedge aclk);
    gpio_in = 32'h4;
    repeat (4) @(negedge aclk);
    axi_read(4'hC, 32'h4);
    // rising edge on bit 0 lands in the same cycle as a W1C of bits 0 and 2
    @(negedge aclk);
    gpio_in = 32'h5;
    axi_write(4'hC, 32'h5, 4'hF);
    axi_read(4'hC, 32'h1);
    // an output pin does not raise status
    axi_write(4'h4, 32'h2, 4'hF);
    axi_write(4'hC, 32'hFF, 4'hF);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear irq=%b, required 0", irq); end
    @(negedge aclk);
    gpio_in = 32'h7;
    repeat (5) @(negedge aclk);
    axi_read(4'hC, 32'h0);
    axi_read(4'h8, 32'h7);
    checks++;
    if (irq !== 1'b0 || gpio_oe !== 32'h2) begin
      errors++;
      $display("FAIL dir_mask irq=%b gpio_oe=%h, required 0 00000002", irq, gpio_oe);
    end
  endtask

  task automatic test_backpressure();
    int n;
    logic [31:0] e;
    do_reset();
    @(negedge aclk);
    awaddr = 4'h0; wdata = 32'hA5; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awaddr = 4'h4; wdata = 32'h3C;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bvalid !== 1'b1 || awready !== 1'b0) begin
        errors++;
        $display("FAIL b_hold cycle=%0d bvalid=%b awready=%b, required 1 0", i, bvalid, awready);
      end
      @(negedge aclk);
    end
    bready = 1'b1;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    bready = 1'b0;
    checks++;
    if (gpio_out !== 32'hA5 || gpio_oe !== 32'h3C) begin
      errors++;
      $display("FAIL bp_writes gpio_out=%h gpio_oe=%h, required 000000a5 0000003c", gpio_out, gpio_oe);
    end
    exp_q.push_back(32'hA5);
    araddr = 4'h0; arvalid = 1'b1; rready = 1'b0;
    n = 0;
    while (!arready && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (rvalid !== 1'b1 || rdata !== exp_q[0]) begin
        errors++;
        $display("FAIL r_hold cycle=%0d rvalid=%b rdata=%h, required 1 %h", i, rvalid, rdata, exp_q[0]);
      end
      @(negedge aclk);
    end
    rready = 1'b1;
    e = exp_q.pop_front();
    checks++;
    if (rvalid !== 1'b1 || rdata !== e) begin
      errors++;
      $display("FAIL r_release rvalid=%b rdata=%h, required 1 %h", rvalid, rdata, e);
    end
    @(negedge aclk);
    rready = 1'b0;
    checks++;
    if (rvalid !== 1'b0) begin errors++; $display("FAIL r_drop rvalid=%b, required 0", rvalid); end
  endtask

  task automatic test_split();
    int bcnt, rcnt;
    bit aw_hs, ar_hs, same;
    logic [31:0] e;
    @(negedge aclk);
    awaddr = 4'h0; wdata = 32'h77; wstrb = 4'hF; awvalid = 1'b1; bready = 1'b1; rready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge aclk);
      checks++;
      if (awready !== 1'b0 || wready !== 1'b0) begin
        errors++;
        $display("FAIL aw_only cycle=%0d awready=%b wready=%b, required 0 0", i, awready, wready);
      end
    end
    wvalid = 1'b1; araddr = 4'h4; arvalid = 1'b1;
    exp_q.push_back(32'h3C);
    bcnt = 0; rcnt = 0; aw_hs = 1'b0; ar_hs = 1'b0; same = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(negedge aclk);
      if (aw_hs) begin awvalid = 1'b0; wvalid = 1'b0; end
      if (ar_hs) arvalid = 1'b0;
      aw_hs = awready && wready;
      ar_hs = arready;
      if (bvalid) bcnt++;
      if (bvalid && rvalid) same = 1'b1;
      if (rvalid && exp_q.size() > 0) begin
        rcnt++;
        e = exp_q.pop_front();
        checks++;
        if (rdata !== e) begin errors++; $display("FAIL split_read rdata=%h, required %h", rdata, e); end
      end
    end
    bready = 1'b0; rready = 1'b0;
    checks++;
    if (bcnt != 1 || rcnt != 1 || !same) begin
      errors++;
      $display("FAIL split_counts bvalid_cycles=%0d reads=%0d same_cycle=%0d, required 1 1 1", bcnt, rcnt, same);
    end
    axi_read(4'h0, 32'h77);
  endtask

  task automatic test_reset_midflight();
    int n;
    gpio_in = {GW{1'b0}};
    @(negedge aclk);
    awaddr = 4'h4; wdata = 32'h1; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b0;
    n = 0;
    while (!(awready && wready) && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    checks++;
    if (bvalid !== 1'b1) begin errors++; $display("FAIL pre_reset bvalid=%b, required 1", bvalid); end
    #1 areset = 1'b1;
    #1;
    checks++;
    if (bvalid !== 1'b0 || gpio_out !== 32'd0 || gpio_oe !== 32'd0 || irq !== 1'b0) begin
      errors++;
      $display("FAIL async_reset bvalid=%b gpio_out=%h gpio_oe=%h irq=%b, required all 0",
               bvalid, gpio_out, gpio_oe, irq);
    end
    @(negedge aclk);
    @(negedge aclk);
    areset = 1'b0;
    for (int i = 0; i < 4; i++) axi_read(4'(i * 4), 32'd0);
  endtask

  task automatic test_first_edge();
    int n;
    areset = 1'b1;
    @(negedge aclk);
    awaddr = 4'h0; wdata = 32'h9; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    @(negedge aclk);
    areset = 1'b0;
    @(negedge aclk);
    checks++;
    if (awready !== 1'b1 || wready !== 1'b1) begin
      errors++;
      $display("FAIL first_edge awready=%b wready=%b, required 1 1", awready, wready);
    end
    @(negedge aclk);
    awvalid = 1'b0; wvalid = 1'b0;
    n = 0;
    while (!bvalid && n < 20) begin @(negedge aclk); n++; end
    @(negedge aclk);
    bready = 1'b0;
    axi_read(4'h0, 32'h9);
  endtask

  initial begin
    areset = 1'b1;
    awaddr = 4'h0; awprot = 3'd0; awvalid = 1'b0; wdata = 32'd0; wstrb = 4'h0; wvalid = 1'b0;
    bready = 1'b0; araddr = 4'h0; arprot = 3'd0; arvalid = 1'b0; rready = 1'b0;
    gpio_in = {GW{1'b0}};
    test_reset();
    test_basic_rw();
    test_strobe();
    test_irq();
    test_backpressure();
    test_split();
    test_reset_midflight();
    test_first_edge();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
